kb_cmd_ctrl: RTL
================

# kb_cmd_ctrl

Keyboard command controller between the PS/2 receiver and the game FSM. It consumes the receiver's byte stream (`NewKB` pulse plus `KB_DAT`). It tracks the scan-code-set-2 `E0`/`F0` prefixes, maps make codes to 3-bit game commands, and queues them in a 4-entry FIFO behind a valid/ready handshake. Break sequences, unmapped codes and stalled prefixes are discarded. Queue overflow is counted.

## Interface
Parameters:
- `TO_CYC`, default 1000000: prefix timeout in `CLK` cycles (20 ms at 50 MHz); legal range 2..2^24-1.

Ports:
- `CLK`  in  1  system clock; single clock domain.
- `RESET`  in  1  reset, synchronous, active-high.
- `NewKB`  in  1  one-cycle strobe: `KB_DAT` holds a new received byte.
- `KB_DAT`  in  8  received byte; sampled only when `NewKB`=1.
- `CMD_VALID`  out  1  FIFO non-empty.
- `CMD`  out  3  head-of-FIFO command: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 PLACE, 5 ROTATE, 6 START, 7 ESC.
- `CMD_RDY`  in  1  consumer accepts `CMD` when `CMD_VALID`&`CMD_RDY`.
- `FIFO_LVL`  out  3  entries held, 0..4.
- `DROP_CNT`  out  8  commands lost to full FIFO; saturates at 255.

## Operation
- Prefix FSM states are IDLE, EXT, BRK and EXT_BRK. Transitions happen only on `NewKB`=1, or on timeout.
  - Byte `E0`, in any state: go to EXT.
  - Byte `F0` in IDLE or BRK: go to BRK.
  - Byte `F0` in EXT or EXT_BRK: go to EXT_BRK.
  - Any other byte in IDLE: look it up in the normal table, then go to IDLE.
  - Any other byte in EXT: look it up in the extended table, then go to IDLE.
  - Any other byte in BRK or EXT_BRK: discard it (no push), then go to IDLE.
- Normal table:
  - `1D`, `75` → UP
  - `1B`, `72` → DOWN
  - `1C`, `6B` → LEFT
  - `23`, `74` → RIGHT
  - `29` → PLACE
  - `2D` → ROTATE
  - `5A` → START
  - `76` → ESC
- Extended table:
  - `75` → UP
  - `72` → DOWN
  - `6B` → LEFT
  - `74` → RIGHT
- An unmapped byte produces no push; the FSM still returns to IDLE.
- Timeout counter:
  - Clears on every `NewKB`.
  - Increments each cycle while the state is not IDLE.
  - When the count reaches `TO_CYC`-1, the state goes to IDLE and the counter clears.
  - If `NewKB` arrives in the same cycle as the timeout, `NewKB` wins: the byte is processed from the current state.
- FIFO: 4 entries, first-in first-out.
  - Pop occurs when `CMD_VALID`&`CMD_RDY`.
  - Push occurs on a mapped byte.
  - Push while full with no pop: the command is dropped and `DROP_CNT` increments, saturating at 255.
  - Push and pop in the same cycle while full: both occur; `FIFO_LVL` stays 4 and nothing is dropped.
  - Push and pop in the same cycle while empty cannot happen, because `CMD_VALID`=0.
- Reset values:
  - State IDLE, timeout counter 0.
  - FIFO empty: `CMD_VALID`=0, `CMD`=0, `FIFO_LVL`=0.
  - `DROP_CNT`=0.
- Reset asserted mid-sequence (e.g. after `E0`) flushes the FIFO and the prefix state. Bytes arriving while `RESET`=1 are ignored.

## Timing
- Decode is combinational on `KB_DAT` and the current state. The push and the state update take effect on the same `CLK` edge that samples `NewKB`=1.
- Latency: `NewKB` in cycle n into an empty FIFO gives `CMD_VALID`=1 and a valid `CMD` in cycle n+1.
- `CMD` is driven from the FIFO head register, so it is glitch-free.
- `CMD` is stable while `CMD_VALID`=1 and `CMD_RDY`=0.
- After a pop, the next entry appears in the following cycle; back-to-back pops sustain 1 command per cycle.
- `FIFO_LVL` and `DROP_CNT` update on the same edge as the push/pop that changes them.
- Upstream guarantees `NewKB` pulses are at least 2 cycles apart. Behaviour on adjacent pulses still processes each byte in order.

## Test plan
- Reset, then `NewKB` with `KB_DAT`=`1D` in cycle 5 → `CMD_VALID`=1 and `CMD`=0 in cycle 6, `FIFO_LVL`=1; hold `CMD_RDY`=1 → `FIFO_LVL`=0 in cycle 7.
- Stream `E0`,`6B`, then `E0`,`F0`,`6B`, then `F0`,`29`, then `12` → exactly one push, `CMD`=2 (LEFT); state IDLE at end.
- `CMD_RDY`=0, six mapped bytes (`29`,`2D`,`5A`,`76`,`1C`,`23`) → `FIFO_LVL`=4, `DROP_CNT`=2; pops then yield 4,5,6,7 in order.
- With the FIFO full and `CMD_RDY`=1, push `1B` in the same cycle as a pop → `FIFO_LVL` stays 4, `DROP_CNT` unchanged, last entry=1.
- `TO_CYC`=16: send `E0`, wait 20 cycles, send `75` → `CMD`=0 (UP, via the normal table after timeout); repeat with a 10-cycle wait → `CMD`=0 via the extended table; state=IDLE both times.
- Send `E0`, assert `RESET` for 1 cycle with 3 entries queued, then send `72` → after reset `FIFO_LVL`=0, `DROP_CNT`=0; `72` decodes as DOWN from IDLE.

Source files
------------

// File: rtl/kb_cmd_ctrl.sv
// Keyboard command controller: tracks scan-code-set-2 E0/F0 prefixes,
// maps make codes to 3-bit game commands and queues them in a 4-entry FIFO.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no prefix pending; next byte decoded with normal table
// EXT     | E0 seen; next byte decoded with extended table
// BRK     | F0 seen; next non-prefix byte is discarded
// EXT_BRK | E0 F0 seen; next non-prefix byte is discarded
module kb_cmd_ctrl #(
    parameter int TO_CYC = 1000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       NewKB,
    input  logic [7:0] KB_DAT,
    output logic       CMD_VALID,
    output logic [2:0] CMD,
    input  logic       CMD_RDY,
    output logic [2:0] FIFO_LVL,
    output logic [7:0] DROP_CNT
);

    // Timer counts down from TO_CYC-1; reaching zero outside IDLE is the timeout.
    localparam logic [23:0] TO_LOAD = 24'(TO_CYC - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} prefixState_t;

    prefixState_t state, stateNext;
    logic [23:0]  timer, timerNext;
    logic         pushReq;
    logic [2:0]   pushCmd;

    logic [2:0]   fifoMem [4];
    logic [1:0]   rdPtr, wrPtr;
    logic [2:0]   level;
    logic [7:0]   dropCnt;
    logic         fifoFull, doPop, doPush, doDrop;

    // Returns {mapped, cmd} for the normal (unprefixed) table.
    function automatic logic [3:0] normalMap(input logic [7:0] b);
        case (b)
            8'h1D, 8'h75: normalMap = 4'b1_000;
            8'h1B, 8'h72: normalMap = 4'b1_001;
            8'h1C, 8'h6B: normalMap = 4'b1_010;
            8'h23, 8'h74: normalMap = 4'b1_011;
            8'h29:        normalMap = 4'b1_100;
            8'h2D:        normalMap = 4'b1_101;
            8'h5A:        normalMap = 4'b1_110;
            8'h76:        normalMap = 4'b1_111;
            default:      normalMap = 4'b0_000;
        endcase
    endfunction

    // Returns {mapped, cmd} for the E0-prefixed table.
    function automatic logic [3:0] extMap(input logic [7:0] b);
        case (b)
            8'h75:   extMap = 4'b1_000;
            8'h72:   extMap = 4'b1_001;
            8'h6B:   extMap = 4'b1_010;
            8'h74:   extMap = 4'b1_011;
            default: extMap = 4'b0_000;
        endcase
    endfunction

    // Prefix next-state, timeout timer and decode of the incoming byte.
    always_comb begin
        stateNext = state;
        timerNext = timer;
        pushReq   = 1'b0;
        pushCmd   = 3'd0;
        if (NewKB) begin
            timerNext = TO_LOAD;
            case (KB_DAT)
                8'hE0: stateNext = EXT;
                8'hF0: stateNext = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
                default: begin
                    stateNext = IDLE;
                    if (state == IDLE)
                        {pushReq, pushCmd} = normalMap(KB_DAT);
                    else if (state == EXT)
                        {pushReq, pushCmd} = extMap(KB_DAT);
                end
            endcase
        end else if (state != IDLE) begin
            if (timer == 24'd0) begin
                stateNext = IDLE;
                timerNext = TO_LOAD;
            end else begin
                timerNext = timer - 24'd1;
            end
        end
    end

    // Prefix state and timer registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            timer <= TO_LOAD;
        end else begin
            state <= stateNext;
            timer <= timerNext;
        end
    end

    assign fifoFull = (level == 3'd4);
    assign doPop    = CMD_VALID & CMD_RDY;
    assign doPush   = pushReq & (~fifoFull | doPop);
    assign doDrop   = pushReq & fifoFull & ~doPop;

    // Command FIFO storage, pointers, fill level and saturating drop counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) fifoMem[i] <= 3'd0;
            rdPtr   <= 2'd0;
            wrPtr   <= 2'd0;
            level   <= 3'd0;
            dropCnt <= 8'd0;
        end else begin
            if (doPop) rdPtr <= rdPtr + 2'd1;
            if (doPush) begin
                fifoMem[wrPtr] <= pushCmd;
                wrPtr          <= wrPtr + 2'd1;
            end
            case ({doPush, doPop})
                2'b10:   level <= level + 3'd1;
                2'b01:   level <= level - 3'd1;
                default: level <= level;
            endcase
            if (doDrop && dropCnt != 8'hFF) dropCnt <= dropCnt + 8'd1;
        end
    end

    assign CMD_VALID = (level != 3'd0);
    assign CMD       = fifoMem[rdPtr];
    assign FIFO_LVL  = level;
    assign DROP_CNT  = dropCnt;

endmodule
